pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 124 ++++++++++++
 tb/tb_pipe_adder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Segmented pipelined adder with valid/ready flow control: each stage adds
// SEG bits and hands its carry on, so a result emerges NSEG cycles after acceptance.
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = (SEG >= 1) ? WIDTH / SEG : 1;

  if (SEG < 1) begin : g_bad_seg
    $error("pipe_adder: SEG must be at least 1");
  end else if (WIDTH % SEG != 0) begin : g_bad_width
    $error("pipe_adder: WIDTH must be a multiple of SEG");
  end

  logic [NSEG-1:0] vld;
  logic [NSEG-1:0] ld;

  // A stage loads if any stage from it to the output is empty, or the output drains.
  for (genvar k = 0; k < NSEG; k++) begin : g_ld
    assign ld[k] = out_ready | ~(&vld[NSEG-1:k]);
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int IN_W = WIDTH - k * SEG;

    logic [IN_W-1:0]  a_in;
    logic [IN_W-1:0]  b_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;
    logic             v_in;
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] s_d;
    logic             vld_q;
    logic             cy_q;
    logic [WIDTH-1:0] sum_q;

    if (k == 0) begin : g_src
      assign a_in = a;
      assign b_in = b;
      assign s_in = '0;
      assign c_in = ci;
      assign v_in = in_valid;
    end else begin : g_src
      assign a_in = g_stage[k-1].g_fwd.opa_q;
      assign b_in = g_stage[k-1].g_fwd.opb_q;
      assign s_in = g_stage[k-1].sum_q;
      assign c_in = g_stage[k-1].cy_q;
      assign v_in = g_stage[k-1].vld_q;
    end

    assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

    always_comb begin
      s_d = s_in;
      s_d[k*SEG +: SEG] = seg_sum[SEG-1:0];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (ld[k]) begin
        vld_q <= v_in;
        cy_q  <= seg_sum[SEG];
        sum_q <= s_d;
      end
    end

    assign vld[k] = vld_q;

    if (k < NSEG - 1) begin : g_fwd
      // Only the not-yet-added operand bits travel on, shrinking stage by stage.
      localparam int REM = IN_W - SEG;
      logic [REM-1:0] opa_q;
      logic [REM-1:0] opb_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (ld[k]) begin
          opa_q <= a_in[IN_W-1:SEG];
          opb_q <= b_in[IN_W-1:SEG];
        end
      end
    end else begin : g_out
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB is recovered as a^b^sum at that bit.
      assign ovf_d = a_in[SEG-1] ^ b_in[SEG-1] ^ seg_sum[SEG-1] ^ seg_sum[SEG];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (ld[k]) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign in_ready  = rst_n & ld[0];
  assign out_valid = g_stage[NSEG-1].vld_q;
  assign s         = g_stage[NSEG-1].sum_q;
  assign cout      = g_stage[NSEG-1].cy_q;
  assign ovf       = g_stage[NSEG-1].g_out.ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed vector table, random traffic against an
// arithmetic reference queue, stall/reset corner cases and a width sweep.
module tb_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, ci, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, s;

  pipe_adder #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  // Width sweep instances, all fed a=b=all-ones, ci=1.
  logic        sw_valid, sw_rdy, sw_ci;
  logic        r8, v8, c8, o8, r16, v16, c16, o16, r12, v12, c12, o12;
  logic [7:0]  a8, s8;
  logic [15:0] a16, s16;
  logic [11:0] a12, s12;

  pipe_adder #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r8), .a(a8), .b(a8),
    .ci(sw_ci), .out_valid(v8), .out_ready(sw_rdy), .s(s8), .cout(c8), .ovf(o8)
  );
  pipe_adder #(.WIDTH(16), .SEG(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r16), .a(a16), .b(a16),
    .ci(sw_ci), .out_valid(v16), .out_ready(sw_rdy), .s(s16), .cout(c16), .ovf(o16)
  );
  pipe_adder #(.WIDTH(12), .SEG(3)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r12), .a(a12), .b(a12),
    .ci(sw_ci), .out_valid(v12), .out_ready(sw_rdy), .s(s12), .cout(c12), .ovf(o12)
  );

  int checks   = 0;
  int failures = 0;
  int popped   = 0;
  int accepted = 0;
  logic [33:0] q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tbl[10];

  // Reference: {cout, s, ovf} from plain integer addition and the sign rule.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    logic [32:0] full;
    logic        v;
    full = 33'(x) + 33'(y) + 33'(c);
    v    = (x[31] == y[31]) && (full[31] != x[31]);
    return {full[32], full[31:0], v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    if (!rst_n) begin
      q.delete();
      chk("in_ready_during_reset", 64'(in_ready), 64'd0);
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          chk("result_vs_model", 64'({cout, s, ovf}), 64'(q[0]));
          if (out_ready) begin
            void'(q.pop_front());
            popped++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, ci));
        accepted++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input vec_t v);
    a = v.a; b = v.b; ci = v.ci; in_valid = 1'b1; out_ready = 1'b1;
    chk("single_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      chk("latency_out_valid", 64'(out_valid), 64'(e == 4));
      if (e == 4) begin
        chk("tbl_s", 64'(s), 64'(v.s));
        chk("tbl_cout", 64'(cout), 64'(v.cout));
        chk("tbl_ovf", 64'(ovf), 64'(v.ovf));
      end
      monitor();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int a0, p0;

    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 1'b1};
    tbl[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    tbl[5] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    tbl[6] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0, 1'b0};
    tbl[7] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
    tbl[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[9] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0;
    sw_valid = 1'b0; sw_rdy = 1'b1; sw_ci = 1'b1;
    a8 = '1; a16 = '1; a12 = '1;

    repeat (3) step();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_s", 64'(s), 64'd0);
    chk("reset_cout", 64'(cout), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);

    foreach (tbl[i]) run_single(tbl[i]);

    // Back-to-back stream: results must drain exactly NSEG cycles after the last accept.
    a0 = accepted; p0 = popped; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("stream_accepted", 64'(accepted - a0), 64'd100);
    chk("stream_popped", 64'(popped - p0), 64'd100);

    // Output stalled: pipe fills to NSEG entries and must hold them.
    a0 = accepted; p0 = popped; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      step();
    end
    chk("stall_accepted", 64'(accepted - a0), 64'd4);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    chk("stall_popped", 64'(popped - p0), 64'd4);
    chk("stall_queue_empty", 64'(q.size()), 64'd0);

    // Random valid/ready traffic.
    for (int i = 0; i < 300; i++) begin
      a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    chk("random_queue_empty", 64'(q.size()), 64'd0);

    // Reset with three transactions in flight: none may surface afterwards.
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; ci = 1'b1; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (8) step();
    run_single(tbl[7]);

    // Width sweep: NSEG = 1, 4, 4.
    sw_valid = 1'b1;
    chk("sweep_in_ready", 64'({r8, r16, r12}), 64'b111);
    step();
    sw_valid = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      chk("sweep8_valid", 64'(v8), 64'(e == 1));
      chk("sweep16_valid", 64'(v16), 64'(e == 4));
      chk("sweep12_valid", 64'(v12), 64'(e == 4));
      if (e == 1) chk("sweep8_result", 64'({c8, s8, o8}), 64'({1'b1, 8'hFF, 1'b0}));
      if (e == 4) begin
        chk("sweep16_result", 64'({c16, s16, o16}), 64'({1'b1, 16'hFFFF, 1'b0}));
        chk("sweep12_result", 64'({c12, s12, o12}), 64'({1'b1, 12'hFFF, 1'b0}));
      end
      monitor();
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
